// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared fetch-path widths, constants, stall indices and alignment helper.
package if_stage_pkg;
    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;
    typedef logic [InstAddrBus-1:0] inst_addr_t;
    typedef logic [InstBus-1:0]     inst_t;
    localparam inst_addr_t ZeroWord    = '0;
    localparam inst_t      NOP         = 32'h0;
    localparam logic       ChipEnable  = 1'b1;
    localparam logic       ChipDisable = 1'b0;
    localparam int STALL_PC = 0;
    localparam int STALL_IF = 1;
    localparam int STALL_ID = 2;
    function automatic inst_addr_t align_word(input inst_addr_t a);
        return {a[InstAddrBus-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: control inputs, ROM port and IF/ID outputs of the fetch stage.
interface if_stage_if;
    import if_stage_pkg::*;
    logic [2:0] stall_i;
    logic       flush_i;
    inst_addr_t flush_pc_i;
    logic       branch_flag_i;
    inst_addr_t branch_target_i;
    inst_t      rom_inst_i;
    inst_addr_t rom_addr_o;
    logic       rom_ce_o;
    inst_addr_t id_pc_o;
    inst_t      id_inst_o;
    logic       id_valid_o;
    modport master (
        input  stall_i, flush_i, flush_pc_i, branch_flag_i, branch_target_i, rom_inst_i,
        output rom_addr_o, rom_ce_o, id_pc_o, id_inst_o, id_valid_o
    );
    modport slave (
        output stall_i, flush_i, flush_pc_i, branch_flag_i, branch_target_i, rom_inst_i,
        input  rom_addr_o, rom_ce_o, id_pc_o, id_inst_o, id_valid_o
    );
endinterface

// File: rtl/if_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with flush, bubble and hold behaviour.
module if_id_reg
    import if_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush_i,
    input  logic       stall_if_i,
    input  logic       stall_id_i,
    input  logic       ce_i,
    input  inst_addr_t pc_i,
    input  inst_t      inst_i,
    output inst_addr_t id_pc_o,
    output inst_t      id_inst_o,
    output logic       id_valid_o
);
    inst_addr_t pc_q, pc_d;
    inst_t      inst_q, inst_d;
    logic       valid_q, valid_d;
    logic       load, hold;
    // IF stalled while ID runs inserts a bubble; both stalled freezes the slot.
    always_comb begin
        hold    = stall_if_i && stall_id_i && !flush_i;
        load    = !flush_i && !stall_if_i && ce_i;
        pc_d    = hold ? pc_q    : load ? pc_i   : ZeroWord;
        inst_d  = hold ? inst_q  : load ? inst_i : NOP;
        valid_d = hold ? valid_q : load;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= ZeroWord;
            inst_q  <= NOP;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end
    assign id_pc_o    = pc_q;
    assign id_inst_o  = inst_q;
    assign id_valid_o = valid_q;
endmodule

// File: rtl/if_stage.sv
// if_stage: program counter and ROM chip-enable, feeding the IF/ID register.
// A branch that coincides with a PC stall is dropped; the controller must re-present it.
module if_stage
    import if_stage_pkg::*;
#(
    parameter inst_addr_t RESET_PC = 32'h0000_0000
) (
    input  logic clk,
    input  logic rst,
    if_stage_if.master bus
);
    localparam logic [0:0] OFF = ChipDisable;
    localparam logic [0:0] RUN = ChipEnable;
    logic [0:0] ce_q, ce_d;
    inst_addr_t pc_q, pc_d;
    // The PC keeps RESET_PC on the edge that brings ce up, so the first fetch is RESET_PC.
    always_comb begin
        ce_d = RUN;
        pc_d = (ce_q == OFF)                 ? RESET_PC :
               bus.flush_i                   ? align_word(bus.flush_pc_i) :
               bus.stall_i[STALL_PC]         ? pc_q :
               bus.branch_flag_i             ? align_word(bus.branch_target_i) :
                                               pc_q + inst_addr_t'(4);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ce_q <= OFF;
            pc_q <= RESET_PC;
        end else begin
            ce_q <= ce_d;
            pc_q <= pc_d;
        end
    end
    assign bus.rom_addr_o = pc_q;
    assign bus.rom_ce_o   = (ce_q == RUN);
    if_id_reg u_if_id (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (bus.flush_i),
        .stall_if_i (bus.stall_i[STALL_IF]),
        .stall_id_i (bus.stall_i[STALL_ID]),
        .ce_i       (ce_q == RUN),
        .pc_i       (pc_q),
        .inst_i     (bus.rom_inst_i),
        .id_pc_o    (bus.id_pc_o),
        .id_inst_o  (bus.id_inst_o),
        .id_valid_o (bus.id_valid_o)
    );
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard bench; expected IF/ID transfers are queued as stimulus is driven.
module tb_if_stage;
    logic clk;
    logic rst;
    int total;
    int bad;
    logic [63:0] sb_q[$];
    logic edge_hold;
    if_stage_if bus();
    if_stage #(.RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));

    // ROM model: word i holds i+1
    assign bus.rom_inst_i = (bus.rom_addr_o >> 2) + 32'd1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst);
        sb_q.push_back({pc, inst});
    endtask

    task automatic chk_reset_outs(input string tag);
        check({tag, "_ce"}, 64'(bus.rom_ce_o), 64'd0);
        check({tag, "_addr"}, 64'(bus.rom_addr_o), 64'd0);
        check({tag, "_idpc"}, 64'(bus.id_pc_o), 64'd0);
        check({tag, "_idinst"}, 64'(bus.id_inst_o), 64'd0);
        check({tag, "_idvalid"}, 64'(bus.id_valid_o), 64'd0);
    endtask

    always @(posedge clk)
        edge_hold = bus.stall_i[2] && bus.stall_i[1] && !rst && !bus.flush_i;

    always @(negedge clk) begin
        if (bus.id_valid_o && !edge_hold) begin
            if (sb_q.size() == 0)
                check("sb_unexpected", {bus.id_pc_o, bus.id_inst_o}, 64'hx);
            else
                check("sb_id", {bus.id_pc_o, bus.id_inst_o}, sb_q.pop_front());
        end
    end

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        bus.stall_i = 3'b000;
        bus.flush_i = 1'b0;
        bus.flush_pc_i = 32'h0;
        bus.branch_flag_i = 1'b0;
        bus.branch_target_i = 32'h0;
        step(2);
        chk_reset_outs("reset");
        rst = 1'b0;
        step(1);
        check("ce_up", 64'(bus.rom_ce_o), 64'd1);
        check("first_addr", 64'(bus.rom_addr_o), 64'd0);
        check("first_valid", 64'(bus.id_valid_o), 64'd0);
        push(32'h0, 32'd1);
        push(32'h4, 32'd2);
        step(2);
        check("run_addr", 64'(bus.rom_addr_o), 64'h8);
        bus.stall_i = 3'b011;
        for (int i = 0; i < 2; i++) begin
            step(1);
            check("s011_addr", 64'(bus.rom_addr_o), 64'h8);
            check("s011_bubble", 64'(bus.id_valid_o), 64'd0);
        end
        bus.stall_i = 3'b000;
        push(32'h8, 32'd3);
        step(1);
        check("s011_release_addr", 64'(bus.rom_addr_o), 64'hC);
        bus.stall_i = 3'b111;
        for (int i = 0; i < 2; i++) begin
            step(1);
            check("s111_addr", 64'(bus.rom_addr_o), 64'hC);
            check("s111_id", {bus.id_pc_o, bus.id_inst_o}, {32'h8, 32'd3});
            check("s111_valid", 64'(bus.id_valid_o), 64'd1);
        end
        bus.stall_i = 3'b000;
        bus.branch_flag_i = 1'b1;
        bus.branch_target_i = 32'h40;
        push(32'hC, 32'd4);
        step(1);
        check("br_addr", 64'(bus.rom_addr_o), 64'h40);
        bus.branch_flag_i = 1'b0;
        push(32'h40, 32'd17);
        step(1);
        check("br_next_addr", 64'(bus.rom_addr_o), 64'h44);
        bus.flush_i = 1'b1;
        bus.flush_pc_i = 32'h20;
        bus.branch_flag_i = 1'b1;
        bus.branch_target_i = 32'h80;
        bus.stall_i = 3'b001;
        step(1);
        check("flush_addr", 64'(bus.rom_addr_o), 64'h20);
        check("flush_squash", 64'(bus.id_valid_o), 64'd0);
        bus.flush_i = 1'b0;
        bus.branch_flag_i = 1'b0;
        bus.stall_i = 3'b000;
        push(32'h20, 32'd9);
        step(1);
        check("flush_next_addr", 64'(bus.rom_addr_o), 64'h24);
        bus.branch_flag_i = 1'b1;
        bus.branch_target_i = 32'hFFFF_FFFD;
        push(32'h24, 32'd10);
        step(1);
        check("wrap_target", 64'(bus.rom_addr_o), 64'hFFFF_FFFC);
        bus.branch_flag_i = 1'b0;
        push(32'hFFFF_FFFC, 32'h4000_0000);
        step(1);
        check("wrap_zero", 64'(bus.rom_addr_o), 64'h0);
        push(32'h0, 32'd1);
        step(1);
        rst = 1'b1;
        bus.stall_i = 3'b111;
        bus.flush_i = 1'b1;
        bus.flush_pc_i = 32'h100;
        bus.branch_flag_i = 1'b1;
        bus.branch_target_i = 32'h200;
        step(1);
        chk_reset_outs("midrst");
        rst = 1'b0;
        bus.stall_i = 3'b000;
        bus.flush_i = 1'b0;
        bus.branch_flag_i = 1'b0;
        step(1);
        check("midrst_ce", 64'(bus.rom_ce_o), 64'd1);
        check("midrst_valid", 64'(bus.id_valid_o), 64'd0);
        push(32'h0, 32'd1);
        step(1);
        check("midrst_addr", 64'(bus.rom_addr_o), 64'h4);
        step(1);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch front end of the five-stage core. It owns the program counter and drives the instruction ROM. It registers each fetched instruction with its PC into the IF/ID boundary that the decode stage consumes. It is the producer of the decoder's `pc_i` and `inst_i`, and honours pipeline stalls, taken branches (the delay slot executes) and exception flushes.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: reset, synchronous, active-high.
- `stall_i`  in  3: stall vector. [0] hold PC, [1] hold IF, [2] hold ID.
- `flush_i`  in  1: exception flush. Redirect to `flush_pc_i` and squash IF/ID.
- `flush_pc_i`  in  32: exception/return vector.
- `branch_flag_i`  in  1: taken branch resolved in ID this cycle.
- `branch_target_i`  in  32: branch destination.
- `rom_inst_i`  in  32: instruction word. Combinational ROM read of `rom_addr_o`.
- `rom_addr_o`  out  32: fetch address. Equals `pc`.
- `rom_ce_o`  out  1: ROM chip enable.
- `id_pc_o`  out  32: PC of the instruction presented to ID.
- `id_inst_o`  out  32: instruction presented to ID. NOP = 32'h0.
- `id_valid_o`  out  1: `id_inst_o` is a real fetched instruction, not a bubble.

## Operation
- The chip-enable register `ce` has two states, OFF and RUN.
  - OFF→RUN on the first edge with `rst`=0.
  - Any edge with `rst`=1 → OFF.
  - `rom_ce_o`=`ce`.
- PC update at each edge, first matching rule wins:
  1. `rst`=1 or `ce`=OFF: pc ← RESET_PC.
  2. `flush_i`: pc ← `flush_pc_i`.
  3. `stall_i[0]`: pc holds.
  4. `branch_flag_i`: pc ← `branch_target_i`.
  5. Otherwise: pc ← pc+4.
- PC arithmetic:
  - Addition is modulo 2^32, so 32'hFFFF_FFFC+4 = 0.
  - Low two bits of every loaded target (flush or branch) are forced to 00.
- IF/ID register update at each edge, first matching rule wins:
  1. `rst` or `flush_i`: {pc, inst, valid} ← {0, 0, 0}.
  2. `stall_i[1]`=1 and `stall_i[2]`=0: bubble, {0, 0, 0}.
  3. `stall_i[1]`=1 and `stall_i[2]`=1: hold.
  4. `ce`=OFF: {0, 0, 0}.
  5. Otherwise: {pc, `rom_inst_i`, 1}.
- Branch delay slot: the instruction fetched in the cycle `branch_flag_i` is high still enters ID. It is never squashed by a branch, only by a flush.
- Stall vector legality:
  - `stall_i` is monotone ({1,1,0} implies {1,0,0}).
  - Vectors with a lower bit set above a cleared bit are undefined input.
  - The block must not lock up on them; it applies the rules literally.
- `branch_flag_i` concurrent with `stall_i[0]`: the branch is lost. The controller must re-present it after the stall. Document this as a controller obligation; the block does not latch it.

## Timing
- Reset values after any `rst` edge:
  - `rom_ce_o`=0, `rom_addr_o`=RESET_PC.
  - `id_pc_o`=0, `id_inst_o`=0, `id_valid_o`=0.
- First edge with `rst` low: `ce`→RUN. PC stays RESET_PC by rule 1, evaluated on the old `ce`.
- Second edge: ID receives {RESET_PC, mem[RESET_PC], 1], and PC→RESET_PC+4.
- Fetch-to-ID latency: 1 cycle. Throughput: one instruction per cycle when unstalled.
- Branch: target appears on `rom_addr_o` one cycle after `branch_flag_i`. The target instruction reaches ID two cycles after it.
- Flush: `id_valid_o`=0 the cycle after the flush edge. The `flush_pc_i` instruction reaches ID one cycle later.
- `rst` mid-stream overrides stall, flush and branch in the same edge.

## Structure
- The shared defines header supplies:
  - `InstAddrBus`, `InstBus`, `ZeroWord`.
  - `ChipEnable`/`ChipDisable`.
  - Stall bit indices `STALL_PC`, `STALL_IF`, `STALL_ID`.
  - NOP encoding 32'h0.
- One sub-module, `if_id_reg`, holds the IF/ID pipeline register and its bubble/hold/flush rules.
- The PC and `ce` logic stays in `if_stage`.

## Test plan
- Reset then run, RESET_PC=0, ROM[i]=i+1: ID sees (0,1), (4,2), (8,3) on consecutive cycles. `id_valid_o` first rises on the second post-reset edge.
- Stall vector 3'b011 for 2 cycles at pc=8: `rom_addr_o` holds 8; ID gets two bubbles (valid=0). Then (8,3) after release.
- Stall vector 3'b111 for 2 cycles: PC and ID outputs both hold their values.
- `branch_flag_i`=1, target 32'h40 at pc=0xC: ID gets (0xC, slot), then (0x40, ROM[0x40]).
- `flush_i` with `flush_pc_i`=32'h20 in the same cycle as `branch_flag_i` and stall 3'b001: PC→0x20 and ID squashed to valid=0.
- PC wrap: branch to 32'hFFFF_FFFD then run. Fetch addresses are 0xFFFF_FFFC, then 0x0.
- `rst` asserted for 1 cycle mid-stream: all outputs return to their reset values.
